mul_div_unit: RTL

//  Iterative multiply/divide unit for the MIPS150 datapath; sits beside the ALU in EX.

---
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative multiply/divide unit with dedicated HI/LO registers.
//                MULT/MULTU/DIV/DIVU finish in WIDTH+1 cycles (one radix-2
//                step per cycle on operand magnitudes, then a sign fix-up).
//                MTHI/MTLO write HI/LO in a single cycle.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous reset, active low
//                start  - request, sampled only while idle
//                op     - 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO
//                a, b   - operands (a is also the MTHI/MTLO source)
//                flush  - cancel in-flight op / suppress same-cycle start
//                busy   - op in progress
//                done   - one-cycle pulse when HI/LO take a new result
//                hi, lo - HI / LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FIXUP = 2'd2;

   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   r_opnd;     // mul: multiplicand magnitude; div: divisor magnitude
   logic               r_is_div;
   logic               r_neg_res;  // result (product / quotient) must be negated
   logic               r_neg_rem;  // remainder must be negated (dividend was negative)
   logic               r_div0;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   // op[0] marks the signed variants of the arithmetic ops
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_add;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_trial;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_a_neg = op[0] & a[WIDTH-1];
   assign w_b_neg = op[0] & b[WIDTH-1];
   // |MIN| stays MIN, which read as unsigned is the correct magnitude
   assign w_a_mag = w_a_neg ? -a : a;
   assign w_b_mag = w_b_neg ? -b : b;

   // Shift-add: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right.
   assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
   assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

   // Restoring division: shift next dividend bit into the remainder and
   // keep the difference only when it did not borrow.
   assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
   assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_prod = r_neg_res ? -r_acc : r_acc;
   assign w_quo  = r_div0 ? '1 : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
   // With a zero divisor the remainder is |a| and the sign fix yields a again
   assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opnd    <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= 1'b0;
         if (flush && r_state != S_IDLE) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && !flush) begin
                     case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                           r_state   <= S_RUN;
                           r_cnt     <= CW'(WIDTH);
                           r_is_div  <= op[1];
                           r_neg_res <= w_a_neg ^ w_b_neg;
                           r_neg_rem <= w_a_neg;
                           r_div0    <= op[1] & (b == '0);
                           r_acc     <= op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
                           r_opnd    <= op[1] ? w_b_mag : w_a_mag;
                        end
                        3'd4:    r_hi <= a;
                        3'd5:    r_lo <= a;
                        default: ;
                     endcase
                  end
               end
               S_RUN: begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) begin
                     r_state <= S_FIXUP;
                  end
               end
               S_FIXUP: begin
                  if (r_is_div) begin
                     r_hi <= w_rem;
                     r_lo <= w_quo;
                  end else begin
                     r_hi <= w_prod[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod[WIDTH-1:0];
                  end
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

`default_nettype wire
